// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// Holds the FSM state encoding, the coin-select enum and the coin values.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_t;

    localparam int unsigned Q_VALUE = 25;
    localparam int unsigned D_VALUE = 10;
    localparam int unsigned N_VALUE = 5;

    function automatic int unsigned coin_value(input coin_t coin);
        case (coin)
            COIN_Q:  return Q_VALUE;
            COIN_D:  return D_VALUE;
            default: return N_VALUE;
        endcase
    endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Hopper-acknowledge watchdog: counts WAIT_ACK cycles and flags expiry
// on the last allowed cycle so the FSM can fault on that edge.
module vend_ack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic Clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer;

    // Saturates at LAST so a stalled FSM never wraps back to a non-expired count.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable && !expire) begin
            timer <= timer + 1'b1;
        end
    end

    assign expire = (timer == LAST);

endmodule

// File: rtl/vend_change_dispenser.sv
// Greedy change-return sequencer driving a quarter/dime/nickel hopper one
// coin at a time with a pulse/acknowledge handshake and ack timeout.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 9,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amt_in,
    input  logic             hop_ack,
    output logic             q_out,
    output logic             d_out,
    output logic             n_out,
    output logic             busy,
    output logic             done,
    output logic [2:0]       residue,
    output logic             err
);

    localparam logic [AMT_W-1:0] Q_AMT = AMT_W'(Q_VALUE);
    localparam logic [AMT_W-1:0] D_AMT = AMT_W'(D_VALUE);
    localparam logic [AMT_W-1:0] N_AMT = AMT_W'(N_VALUE);

    state_t           state;
    coin_t            coin_sel;
    logic [AMT_W-1:0] rem;
    logic             ack_expire;

    vend_ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .Clk    (Clk),
        .rst    (rst),
        .clear  (state == ST_PULSE),
        .enable (state == ST_WAIT_ACK),
        .expire (ack_expire)
    );

    // NOTE: outputs are assigned alongside the state transition with
    // non-blocking writes, so they are registered Moore outputs that match
    // the state they are entering; every register here has an explicit reset.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            coin_sel <= COIN_Q;
            rem      <= '0;
            q_out    <= 1'b0;
            d_out    <= 1'b0;
            n_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            residue  <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem   <= amt_in;
                        busy  <= 1'b1;
                        state <= ST_SELECT;
                    end
                end

                ST_SELECT: begin
                    if (rem >= Q_AMT) begin
                        coin_sel <= COIN_Q;
                        q_out    <= 1'b1;
                        state    <= ST_PULSE;
                    end else if (rem >= D_AMT) begin
                        coin_sel <= COIN_D;
                        d_out    <= 1'b1;
                        state    <= ST_PULSE;
                    end else if (rem >= N_AMT) begin
                        coin_sel <= COIN_N;
                        n_out    <= 1'b1;
                        state    <= ST_PULSE;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        residue <= rem[2:0];
                        state   <= ST_DONE;
                    end
                end

                ST_PULSE: begin
                    q_out <= 1'b0;
                    d_out <= 1'b0;
                    n_out <= 1'b0;
                    state <= ST_WAIT_ACK;
                end

                // An ack on the expiry cycle still counts: the coin did come out.
                ST_WAIT_ACK: begin
                    if (hop_ack) begin
                        rem   <= rem - AMT_W'(coin_value(coin_sel));
                        state <= ST_SELECT;
                    end else if (ack_expire) begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                ST_ERR: begin
                    err <= 1'b1;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed self-checking bench for vend_change_dispenser: greedy coin
// schedule, handshake timing, residue, ack timeout and reset behaviour.
module tb_vend_change_dispenser;

    localparam int AMT_W       = 9;
    localparam int ACK_TIMEOUT = 16;

    logic             Clk;
    logic             rst;
    logic             start;
    logic [AMT_W-1:0] amt_in;
    logic             hop_ack;
    logic             q_out;
    logic             d_out;
    logic             n_out;
    logic             busy;
    logic             done;
    logic [2:0]       residue;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Results of the most recent dispense() run.
    int          r_nq, r_nd, r_nn, r_cyc;
    logic        r_done, r_wide, r_multi, r_busy_bad;
    logic [2:0]  r_res;
    logic [63:0] r_seq;

    vend_change_dispenser #(
        .AMT_W       (AMT_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .Clk     (Clk),
        .rst     (rst),
        .start   (start),
        .amt_in  (amt_in),
        .hop_ack (hop_ack),
        .q_out   (q_out),
        .d_out   (d_out),
        .n_out   (n_out),
        .busy    (busy),
        .done    (done),
        .residue (residue),
        .err     (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        hop_ack = 1'b0;
        amt_in  = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Runs one transaction. ack_delay = extra WAIT_ACK cycles before the ack.
    // poke re-asserts start with amt_in=100 while the first request is busy.
    task automatic dispense(input logic [AMT_W-1:0] amt, input int ack_delay, input bit poke);
        int   wait_ctr;
        logic prev, pulse;
        r_nq = 0; r_nd = 0; r_nn = 0; r_cyc = 0;
        r_done = 1'b0; r_wide = 1'b0; r_multi = 1'b0; r_busy_bad = 1'b0;
        r_res = 3'd7; r_seq = '0;
        wait_ctr = -1;
        prev     = 1'b0;
        amt_in = amt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        r_cyc  = 1;
        while (!r_done && r_cyc < 400) begin
            if (done) begin
                r_done = 1'b1;
                r_res  = residue;
                if (busy) r_busy_bad = 1'b1;
            end else begin
                if (!busy) r_busy_bad = 1'b1;
                if (int'(q_out) + int'(d_out) + int'(n_out) > 1) r_multi = 1'b1;
                pulse = q_out | d_out | n_out;
                if (pulse && prev) r_wide = 1'b1;
                prev = pulse;
                if (q_out) begin r_nq++; r_seq = {r_seq[61:0], 2'd1}; end
                if (d_out) begin r_nd++; r_seq = {r_seq[61:0], 2'd2}; end
                if (n_out) begin r_nn++; r_seq = {r_seq[61:0], 2'd3}; end
                hop_ack = (wait_ctr == 0);
                if (wait_ctr >= 0) wait_ctr--;
                if (pulse) wait_ctr = ack_delay;
                if (poke) begin
                    start  = (r_cyc >= 2 && r_cyc <= 4);
                    amt_in = 100;
                end
                tick();
                r_cyc++;
            end
        end
        hop_ack = 1'b0;
        start   = 1'b0;
        if (r_done) tick();
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        rst = 1'b1; start = 1'b0; hop_ack = 1'b0; amt_in = '0;
        #12;
        outs = {q_out, d_out, n_out, busy, done, err, |residue};
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: outs=%b expected=0000000", outs);
        end
        @(negedge Clk);
        rst = 1'b0;
        tick();
        // Mid-run reset while a quarter pulse is on the wire.
        amt_in = 40;
        start  = 1'b1;
        tick();
        tick();
        checks++;
        if (q_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_pulse: q_out=%b expected=1", q_out);
        end
        #2 rst = 1'b1;
        #1;
        outs = {q_out, d_out, n_out, busy, done, err, |residue};
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: outs=%b expected=0000000", outs);
        end
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        outs = {q_out, d_out, n_out, busy, done, err, |residue};
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL reset_idle_after: outs=%b expected=0000000", outs);
        end
    endtask

    task automatic test_three_coins();
        dispense(40, 0, 1'b0);
        checks++;
        if (!r_done || r_res !== 3'd0 || r_cyc != 11) begin
            errors++;
            $display("FAIL amt40_done: done=%b res=%0d cyc=%0d expected done=1 res=0 cyc=11",
                     r_done, r_res, r_cyc);
        end
        checks++;
        if (r_seq[5:0] !== 6'b01_10_11 || r_nq != 1 || r_nd != 1 || r_nn != 1) begin
            errors++;
            $display("FAIL amt40_seq: seq=%b q=%0d d=%0d n=%0d expected seq=011011 q=1 d=1 n=1",
                     r_seq[5:0], r_nq, r_nd, r_nn);
        end
        checks++;
        if (r_wide || r_multi || r_busy_bad) begin
            errors++;
            $display("FAIL amt40_shape: wide=%b multi=%b busy_bad=%b expected 0 0 0",
                     r_wide, r_multi, r_busy_bad);
        end
        checks++;
        if (done !== 1'b0 || residue !== 3'd0) begin
            errors++;
            $display("FAIL amt40_after: done=%b residue=%0d expected done=0 residue=0", done, residue);
        end
    endtask

    task automatic test_zero();
        dispense(0, 0, 1'b0);
        checks++;
        if (!r_done || r_res !== 3'd0 || r_cyc != 2 || (r_nq + r_nd + r_nn) != 0) begin
            errors++;
            $display("FAIL amt0: done=%b res=%0d cyc=%0d coins=%0d expected done=1 res=0 cyc=2 coins=0",
                     r_done, r_res, r_cyc, r_nq + r_nd + r_nn);
        end
    endtask

    task automatic test_nickel();
        dispense(7, 0, 1'b0);
        checks++;
        if (!r_done || r_res !== 3'd2 || r_nq != 0 || r_nd != 0 || r_nn != 1 || r_cyc != 5) begin
            errors++;
            $display("FAIL amt7: done=%b res=%0d q=%0d d=%0d n=%0d cyc=%0d expected 1 2 0 0 1 5",
                     r_done, r_res, r_nq, r_nd, r_nn, r_cyc);
        end
        checks++;
        if (residue !== 3'd2 || done !== 1'b0) begin
            errors++;
            $display("FAIL amt7_held: residue=%0d done=%b expected residue=2 done=0", residue, done);
        end
    endtask

    task automatic test_max();
        dispense(511, 0, 1'b0);
        checks++;
        if (!r_done || r_res !== 3'd1 || r_nq != 20 || r_nd != 1 || r_nn != 0 || r_cyc != 65) begin
            errors++;
            $display("FAIL amt511: done=%b res=%0d q=%0d d=%0d n=%0d cyc=%0d expected 1 1 20 1 0 65",
                     r_done, r_res, r_nq, r_nd, r_nn, r_cyc);
        end
        checks++;
        if (r_wide || r_multi || r_busy_bad) begin
            errors++;
            $display("FAIL amt511_shape: wide=%b multi=%b busy_bad=%b expected 0 0 0",
                     r_wide, r_multi, r_busy_bad);
        end
    endtask

    task automatic test_ack_delay();
        dispense(19, 3, 1'b0);
        checks++;
        if (!r_done || r_res !== 3'd4 || r_nd != 1 || r_nn != 1 || r_nq != 0 || r_cyc != 14) begin
            errors++;
            $display("FAIL amt19_delay: done=%b res=%0d q=%0d d=%0d n=%0d cyc=%0d expected 1 4 0 1 1 14",
                     r_done, r_res, r_nq, r_nd, r_nn, r_cyc);
        end
    endtask

    task automatic test_timeout();
        int   n;
        logic bad;
        amt_in = 30;
        start  = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!q_out && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (q_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: q_out=%b expected=1", q_out);
        end
        repeat (ACK_TIMEOUT) tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b busy=%b expected err=0 busy=1", err, busy);
        end
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b busy=%b expected err=1 busy=0", err, busy);
        end
        amt_in = 100;
        start  = 1'b1;
        bad    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (q_out || d_out || n_out || done || busy || !err) bad = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL timeout_terminal: activity=%b expected=0", bad);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rst_clear: err=%b expected=0", err);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        dispense(30, 0, 1'b1);
        checks++;
        if (!r_done || r_res !== 3'd0 || r_nq != 1 || r_nd != 0 || r_nn != 1 || r_cyc != 8) begin
            errors++;
            $display("FAIL b2b: done=%b res=%0d q=%0d d=%0d n=%0d cyc=%0d expected 1 0 1 0 1 8",
                     r_done, r_res, r_nq, r_nd, r_nn, r_cyc);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || q_out !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_not_latched: busy=%b q_out=%b done=%b expected 0 0 0", busy, q_out, done);
        end
    endtask

    initial begin
        test_reset();
        test_three_coins();
        test_zero();
        test_nickel();
        test_max();
        test_ack_delay();
        test_timeout();
        test_back_to_back();
        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Change-return sequencer for the vending machine. It takes a change amount in cents from the vending core and drives a three-tube coin hopper (quarter/dime/nickel) one coin at a time, using a greedy largest-coin-first schedule. Each coin is handed to the hopper with a pulse/acknowledge handshake, and a missing acknowledge is caught by a timeout. It sits between the vending core's amount output and the hopper drivers.

Parameters:
AMT_W, 9, width of the change amount in cents (matches the core's amount bus).
ACK_TIMEOUT, 16, cycles to wait in WAIT_ACK before flagging a hopper fault; must be >= 2.

Ports:
Clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to dispense amt_in; sampled only in IDLE.
amt_in  input  AMT_W  change amount in cents, latched on an accepted start.
hop_ack  input  1  hopper acknowledge: coin ejected; sampled only in WAIT_ACK.
q_out  output  1  eject-quarter pulse.
d_out  output  1  eject-dime pulse.
n_out  output  1  eject-nickel pulse.
busy  output  1  high from the cycle after an accepted start until the cycle before IDLE.
done  output  1  one-cycle completion strobe.
residue  output  3  undispensable remainder (0..4 cents); valid while done=1, then held.
err  output  1  hopper timeout fault; sticky until rst.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, rem=0, timer=0.
  - q_out=d_out=n_out=busy=done=err=0, residue=0.
- All outputs are registered (Moore), decoded from state and the registered coin-select.
- IDLE:
  - start=1 at a rising edge latches rem<=amt_in and moves to SELECT.
  - start=0 stays in IDLE.
- SELECT (1 cycle), greedy choice on rem:
  - rem>=25 chooses Q, else rem>=10 chooses D, else rem>=5 chooses N; then go to PULSE.
  - rem<5 goes to DONE.
- PULSE (exactly 1 cycle):
  - Exactly one of q_out/d_out/n_out is high, per the selected coin.
  - Clear timer and go to WAIT_ACK.
  - hop_ack during PULSE is ignored.
- WAIT_ACK:
  - hop_ack=1 at an edge: rem<=rem-coin value (25/10/5) and go to SELECT.
  - Otherwise timer increments. When timer reaches ACK_TIMEOUT-1 with no ack, go to ERR; rem is unchanged.
- DONE (1 cycle): done=1, residue<=rem[2:0], then go to IDLE.
- ERR (terminal): err=1, busy=0, no coin pulses, start ignored; exit only via rst.
- busy is high in SELECT, PULSE and WAIT_ACK, and low in IDLE, DONE and ERR.
- start while not in IDLE is ignored, and amt_in is not re-latched.
- Timing: per coin = SELECT + PULSE + WAIT_ACK cycles (minimum 3 cycles when ack arrives in the first WAIT_ACK cycle). From accepted start to done = 3*coins + 2 + ack delays.
- Arithmetic: rem is AMT_W bits unsigned; subtraction never underflows, because SELECT guarantees rem>=coin.
- Max AMT_W=9 amount 511 gives 20Q + 1D + residue 1.
- Reset mid-operation:
  - Any state returns to IDLE immediately and outputs clear asynchronously.
  - A pulse in progress is truncated.
  - No done strobe is issued.

Decomposition:
- Shared package vend_pkg:
  - State encoding: IDLE, SELECT, PULSE, WAIT_ACK, DONE, ERR.
  - Coin-select enum: COIN_Q, COIN_D, COIN_N.
  - Coin value constants: 25, 10, 5.
- One natural sub-module: vend_ack_timer, the WAIT_ACK timeout counter with clear/enable/expire.
- The greedy selector stays inline.

Test Plan:
- Reset check: assert rst mid-run with start=1 → all outputs 0 asynchronously; state IDLE after release.
- amt_in=40, hop_ack one cycle after each pulse → pulses Q, then D, then N, each exactly 1 cycle. Then done=1 with residue=0; busy drops with done; total 11 cycles from start edge to done.
- amt_in=0 → no coin pulses; done 2 cycles after start; residue=0.
- amt_in=7 → single n_out pulse, then done with residue=2. amt_in=511 → 20 q_out, 1 d_out, 0 n_out pulses, residue=1.
- hop_ack held 0 after a q_out pulse → err=1 after ACK_TIMEOUT cycles in WAIT_ACK; no further pulses; start ignored; rst clears err.
- start re-asserted with amt_in=100 while busy dispensing 30 → still Q+N only, done with residue=0; the second request is not latched.
